// File: rtl/pn_pkg.sv
// Shared definitions for the PN token transmitter: token widths, opcode and
// mode constants, transmitter FSM state encoding and the result-count helper.
package pn_pkg;

    localparam int TOK_W     = 3;
    localparam int TOK_SLOTS = 12;
    localparam int LEN_W     = 4;
    localparam int RES_W     = 32;

    localparam logic [TOK_W-1:0] OP_ADD = 3'd0;
    localparam logic [TOK_W-1:0] OP_SUB = 3'd1;
    localparam logic [TOK_W-1:0] OP_MUL = 3'd2;
    localparam logic [TOK_W-1:0] OP_ABS = 3'd3;

    localparam logic [1:0] MODE_PRE_SORT   = 2'd0;
    localparam logic [1:0] MODE_POST_SORT  = 2'd1;
    localparam logic [1:0] MODE_PRE_STACK  = 2'd2;
    localparam logic [1:0] MODE_POST_STACK = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_COLLECT,
        ST_GAP,
        ST_REJ
    } pn_state_e;

    // Sort modes return one result per operand triple; stack modes return one.
    function automatic logic [2:0] exp_results(
        input logic [1:0]       mode,
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W-1:0] q;
        q = len / LEN_W'(3);
        if (mode == MODE_PRE_SORT || mode == MODE_POST_SORT)
            return q[2:0];
        return 3'd1;
    endfunction

endpackage

// File: rtl/pn_stream_tx_if.sv
// Host + calculator bundle of the PN transmitter.
// master: host/PN side (drives start, cfg_*, pn_out*); slave: the transmitter.
interface pn_stream_tx_if;
    import pn_pkg::*;

    logic                         start;
    logic [1:0]                   cfg_mode;
    logic [LEN_W-1:0]             cfg_len;
    logic [TOK_SLOTS*TOK_W-1:0]   cfg_tok;
    logic [TOK_SLOTS-1:0]         cfg_op;

    logic [1:0]                   mode;
    logic                         operator;
    logic [TOK_W-1:0]             in;
    logic                         in_valid;

    logic                         pn_out_valid;
    logic signed [RES_W-1:0]      pn_out;

    logic                         busy;
    logic                         res_valid;
    logic signed [RES_W-1:0]      res_data;
    logic [1:0]                   res_idx;
    logic                         done;
    logic                         err;

    modport master (
        output start, cfg_mode, cfg_len, cfg_tok, cfg_op,
        output pn_out_valid, pn_out,
        input  mode, operator, in, in_valid,
        input  busy, res_valid, res_data, res_idx, done, err
    );

    modport slave (
        input  start, cfg_mode, cfg_len, cfg_tok, cfg_op,
        input  pn_out_valid, pn_out,
        output mode, operator, in, in_valid,
        output busy, res_valid, res_data, res_idx, done, err
    );

endinterface

// File: rtl/pn_tok_serializer.sv
// Token shift register: load_i captures the first len_i tokens (rest zeroed),
// shift_i advances one token; tok_o/op_o are the head, last_o flags token len-1.
module pn_tok_serializer
    import pn_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic                       shift_i,
    input  logic [LEN_W-1:0]           len_i,
    input  logic [TOK_SLOTS*TOK_W-1:0] tok_i,
    input  logic [TOK_SLOTS-1:0]       op_i,
    output logic [TOK_W-1:0]           tok_o,
    output logic                       op_o,
    output logic                       last_o
);

    logic [TOK_SLOTS*TOK_W-1:0] tok_q, tok_d;
    logic [TOK_SLOTS-1:0]       op_q, op_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic [LEN_W-1:0]           len_q, len_d;

    // Unused slots load as zero so the head reads 0 once the stream is out.
    always_comb begin
        tok_d = tok_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            tok_d = '0;
            op_d  = '0;
            for (int k = 0; k < TOK_SLOTS; k++) begin
                if (k < int'(len_i)) begin
                    tok_d[k*TOK_W +: TOK_W] = tok_i[k*TOK_W +: TOK_W];
                    op_d[k]                 = op_i[k];
                end
            end
            cnt_d = '0;
            len_d = len_i;
        end else if (shift_i) begin
            tok_d = tok_q >> TOK_W;
            op_d  = op_q >> 1;
            cnt_d = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            tok_q <= tok_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign tok_o  = tok_q[TOK_W-1:0];
    assign op_o   = op_q[0];
    assign last_o = (cnt_q + LEN_W'(1)) == len_q;

endmodule

// File: rtl/pn_stream_tx.sv
// PN transmitter: sends one configured expression to the calculator, collects
// its result burst and reports done/err. Ports: clk, rst_n, bus (slave).
module pn_stream_tx
    import pn_pkg::*;
#(
    parameter int MAX_TOK = TOK_SLOTS,
    parameter int TIMEOUT = 256,
    parameter int GAP_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pn_stream_tx_if.slave  bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    pn_state_e               state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic                    in_valid_q, in_valid_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [RES_W-1:0] res_data_q, res_data_d;
    logic [1:0]              res_idx_q, res_idx_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [2:0]              exp_q, exp_d;
    logic [2:0]              rcv_q, rcv_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [GAP_W-1:0]        gap_q, gap_d;

    logic                    ser_load;
    logic                    ser_shift;
    logic [TOK_W-1:0]        ser_tok;
    logic                    ser_op;
    logic                    ser_last;
    logic [2:0]              cfg_exp;
    logic                    cfg_bad;

    pn_tok_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ser_load),
        .shift_i (ser_shift),
        .len_i   (bus.cfg_len),
        .tok_i   (bus.cfg_tok),
        .op_i    (bus.cfg_op),
        .tok_o   (ser_tok),
        .op_o    (ser_op),
        .last_o  (ser_last)
    );

    assign cfg_exp = exp_results(bus.cfg_mode, bus.cfg_len);
    assign cfg_bad = (bus.cfg_len == '0)
                  || (int'(bus.cfg_len) > MAX_TOK)
                  || (cfg_exp == 3'd0);

    always_comb begin
        state_d     = state_q;
        mode_d      = 2'd0;
        in_valid_d  = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = '0;
        res_idx_d   = 2'd0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        exp_d       = exp_q;
        rcv_d       = rcv_q;
        tmr_d       = tmr_q;
        gap_d       = gap_q;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    exp_d = cfg_exp;
                    rcv_d = 3'd0;
                    tmr_d = '0;
                    gap_d = '0;
                    if (cfg_bad) begin
                        state_d = ST_REJ;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_SEND;
                        ser_load   = 1'b1;
                        mode_d     = bus.cfg_mode;
                        in_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                ser_shift = 1'b1;
                if (ser_last) begin
                    state_d = ST_WAIT;
                    // The cycle after the last token is the first idle cycle.
                    tmr_d   = TMR_W'(1);
                end else begin
                    in_valid_d = 1'b1;
                end
            end
            ST_WAIT, ST_COLLECT: begin
                // A beat in the final timer cycle still wins over the timeout.
                if (bus.pn_out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = bus.pn_out;
                    res_idx_d   = rcv_q[1:0];
                    rcv_d       = rcv_q + 3'd1;
                    tmr_d       = TMR_W'(1);
                    if ((rcv_q + 3'd1) == exp_q) begin
                        done_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1))
                    state_d = ST_IDLE;
                else
                    gap_d = gap_q + GAP_W'(1);
            end
            ST_REJ: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'd0;
            in_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            exp_q       <= 3'd0;
            rcv_q       <= 3'd0;
            tmr_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_valid_q  <= in_valid_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            exp_q       <= exp_d;
            rcv_q       <= rcv_d;
            tmr_q       <= tmr_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.operator  = ser_op;
    assign bus.in        = ser_tok;
    assign bus.in_valid  = in_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pn_stream_tx.sv
// Randomized bench for pn_stream_tx: a per-transaction timeline model built
// from token order, result deadlines and gap length, compared every cycle.
module tb_pn_stream_tx;
    import pn_pkg::*;

    localparam int TIMEOUT = 256;
    localparam int GAP_CYC = 2;
    localparam int MAXC    = 1200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pn_stream_tx_if bus();

    pn_stream_tx #(
        .MAX_TOK (12),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit          beat_at  [MAXC];
    logic [31:0] beat_val [MAXC];
    logic [44:0] exp_v    [MAXC];

    task automatic check(input string tag, input logic [44:0] got,
                         input logic [44:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // {busy, in_valid, mode, operator, in, done, err, res_valid, idx, data}
    function automatic logic [44:0] vec(
        input logic b, input logic iv, input logic [1:0] m,
        input logic o, input logic [2:0] t, input logic d,
        input logic e, input logic rv, input logic [1:0] ix,
        input logic [31:0] dat);
        return {b, iv, m, o, t, d, e, rv, ix, dat};
    endfunction

    function automatic logic [44:0] obs();
        logic rv;
        rv = bus.res_valid;
        return vec(bus.busy, bus.in_valid, bus.mode, bus.operator, bus.in,
                   bus.done, bus.err, rv,
                   rv ? bus.res_idx : 2'b0,
                   rv ? bus.res_data : 32'h0);
    endfunction

    task automatic clr_beats();
        for (int c = 0; c < MAXC; c++) begin
            beat_at[c]  = 1'b0;
            beat_val[c] = 32'h0;
        end
    endtask

    task automatic gen_beats(input int len, input int n);
        int c;
        clr_beats();
        if (len > 0 && $urandom_range(0, 1) == 1) begin
            c = $urandom_range(1, len);
            beat_at[c]  = 1'b1;
            beat_val[c] = $urandom;
        end
        c = len + 1 + $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            beat_at[c]  = 1'b1;
            beat_val[c] = $urandom;
            c += $urandom_range(1, 4);
        end
    endtask

    // Caller is at a negedge with the DUT idle. Cycle 1 is the cycle after
    // the edge that samples start.
    task automatic run_txn(input string name, input logic [1:0] m,
                           input logic [3:0] len, input logic [35:0] tok,
                           input logic [11:0] op, input bit noise);
        int  n_exp, ref_c, got, d, end_c;
        bit  rej, e;
        n_exp = (m < 2'd2) ? int'(len) / 3 : 1;
        rej   = (len == 4'd0) || (len > 4'd12) || (n_exp == 0);
        for (int c = 0; c < MAXC; c++) exp_v[c] = '0;
        d = 0;
        e = 1'b0;
        if (rej) begin
            d = 1;
            e = 1'b1;
            end_c = 2;
        end else begin
            for (int k = 0; k < int'(len); k++)
                exp_v[k+1] = vec(1'b1, 1'b1, (k == 0) ? m : 2'b0, op[k],
                                 tok[3*k +: 3], 1'b0, 1'b0, 1'b0, 2'b0,
                                 32'h0);
            ref_c = int'(len);
            got   = 0;
            for (int c = int'(len) + 1; d == 0 && c < MAXC - 8; c++) begin
                if (beat_at[c]) begin
                    exp_v[c+1] = vec(1'b1, 1'b0, 2'b0, 1'b0, 3'b0, 1'b0,
                                     1'b0, 1'b1, got[1:0], beat_val[c]);
                    got++;
                    ref_c = c;
                    if (got == n_exp) d = c + 1;
                end else if (c == ref_c + TIMEOUT - 1) begin
                    d = c + 1;
                    e = 1'b1;
                end
            end
            if (d == 0) d = MAXC - 8;
            end_c = d + GAP_CYC;
        end
        for (int c = 1; c < end_c; c++) exp_v[c][44] = 1'b1;
        exp_v[d][36] = 1'b1;
        exp_v[d][35] = e;

        bus.cfg_mode = m;
        bus.cfg_len  = len;
        bus.cfg_tok  = tok;
        bus.cfg_op   = op;
        bus.start    = 1'b1;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", name, c), obs(), exp_v[c]);
            bus.start = noise && (c < end_c) && ($urandom_range(0, 3) == 0);
            if (noise) begin
                bus.cfg_mode = 2'($urandom);
                bus.cfg_len  = 4'($urandom);
                bus.cfg_tok  = {4'($urandom), $urandom};
                bus.cfg_op   = 12'($urandom);
            end
            bus.pn_out_valid = beat_at[c];
            bus.pn_out       = beat_at[c] ? beat_val[c] : $urandom;
        end
        bus.start        = 1'b0;
        bus.pn_out_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [35:0] t1, t2, t4, tr;
        logic [11:0] o1, o2, o4;
        int          len, n;
        logic [1:0]  m;

        bus.start        = 1'b0;
        bus.cfg_mode     = 2'd0;
        bus.cfg_len      = 4'd0;
        bus.cfg_tok      = '0;
        bus.cfg_op       = '0;
        bus.pn_out_valid = 1'b0;
        bus.pn_out       = '0;
        clr_beats();

        repeat (3) @(negedge clk);
        check("reset", obs(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", obs(), '0);

        // {+,3,4,*,2,5}, operators at tokens 0 and 3
        t1 = {18'd0, 3'd5, 3'd2, 3'd2, 3'd4, 3'd3, 3'd0};
        o1 = 12'b0000_0000_1001;
        clr_beats();
        beat_at[7] = 1'b1; beat_val[7] = 32'd10;
        beat_at[8] = 1'b1; beat_val[8] = 32'd7;
        beat_at[9] = 1'b1; beat_val[9] = 32'd99;
        run_txn("m0_len6", 2'd0, 4'd6, t1, o1, 1'b1);

        // {3,4,+,2,*}, operators at tokens 2 and 4
        t2 = {21'd0, 3'd2, 3'd2, 3'd0, 3'd4, 3'd3};
        o2 = 12'b0000_0001_0100;
        clr_beats();
        beat_at[7] = 1'b1; beat_val[7] = 32'd14;
        beat_at[8] = 1'b1; beat_val[8] = 32'hDEAD;
        run_txn("m3_len5", 2'd3, 4'd5, t2, o2, 1'b1);

        clr_beats();
        beat_at[1] = 1'b1; beat_val[1] = 32'd5;
        run_txn("rej_len0", 2'd0, 4'd0, t1, o1, 1'b0);
        clr_beats();
        run_txn("rej_m1_len2", 2'd1, 4'd2, t1, o1, 1'b1);
        clr_beats();
        run_txn("rej_len13", 2'd2, 4'd13, t1, o1, 1'b0);

        t4 = {27'd0, 3'd2, 3'd1, 3'd0};
        o4 = 12'b0000_0000_0001;
        clr_beats();
        run_txn("m2_timeout", 2'd2, 4'd3, t4, o4, 1'b0);

        clr_beats();
        beat_at[12] = 1'b1; beat_val[12] = 32'hFFFF_FFF6;
        beat_at[15] = 1'b1; beat_val[15] = 32'd3;
        run_txn("m1_partial", 2'd1, 4'd9, {$urandom, 4'($urandom)},
                12'($urandom), 1'b0);

        // Reset while token index 2 of 6 is on the bus.
        bus.cfg_mode = 2'd1;
        bus.cfg_len  = 4'd6;
        bus.cfg_tok  = t1;
        bus.cfg_op   = o1;
        bus.start    = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_send c%0d", c), obs(),
                  vec(1'b1, 1'b1, (c == 1) ? 2'd1 : 2'd0, o1[c-1],
                      t1[3*(c-1) +: 3], 1'b0, 1'b0, 1'b0, 2'b0, 32'h0));
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_async", obs(), '0);
        @(negedge clk);
        check("rst_hold", obs(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", obs(), '0);
        clr_beats();
        beat_at[8] = 1'b1; beat_val[8] = 32'd42;
        run_txn("after_rst", 2'd2, 4'd6, t1, o1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            m   = 2'($urandom);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                              : $urandom_range(1, 12);
            n   = (m < 2'd2) ? len / 3 : 1;
            if ($urandom_range(0, 9) == 0)
                n = (n > 0) ? n - 1 : 0;
            else
                n = n + $urandom_range(0, 2);
            gen_beats(len, n);
            tr = {$urandom, 4'($urandom)};
            run_txn($sformatf("rnd%0d", i), m, 4'(len), tr,
                    12'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
